// File: rtl/pkt_fifo_frame_reader_pkg.sv
// Shared definitions for the packet-body FIFO frame reader.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
package pkt_fifo_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // FIFO word layout, identical to the writer's packing: data in [8:1], EOD in [0].
    localparam int WORD_W   = 9;
    localparam int DATA_MSB = 8;
    localparam int DATA_LSB = 1;
    localparam int EOD_BIT  = 0;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t pack_word(input logic [7:0] dat, input logic eod);
        word_t w;
        w                    = '0;
        w[DATA_MSB:DATA_LSB] = dat;
        w[EOD_BIT]           = eod;
        return w;
    endfunction

endpackage

// File: rtl/pkt_fifo_frame_reader_if.sv
// Byte stream toward the TX MAC: valid/ready/last plus truncation flag.
// Latency: n/a (wiring only).
// Backpressure: sink holds tx_ready low to stall; source keeps its byte stable.
interface pkt_fifo_frame_reader_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_err;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, output tx_err, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, input tx_err, output tx_ready);
endinterface

// File: rtl/pkt_reader_skid.sv
// Two-entry word buffer behind the FIFO read port, tracking the one read in flight.
// Latency: a word is presentable the cycle it arrives (bypass when the buffer is empty).
// Backpressure: count (buffered + in flight) lets the caller stop reading at 2.
module pkt_reader_skid
    import pkt_fifo_frame_reader_pkg::*;
(
    input  logic       clkw,
    input  logic       rst,
    input  logic       push,      // FIFO read accepted this cycle; word arrives next cycle
    input  logic [7:0] data,
    input  logic       eod,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       head_eod,
    output logic       valid,
    output logic [1:0] count,
    output logic       cap_eod    // an EOD word is arriving this cycle
);
    word_t [1:0] ent_q, ent_d;
    logic  [1:0] num_q, num_d;
    logic        infl_q, infl_d;
    word_t       in_word, head_word;
    logic  [1:0] num_mid;

    // Head is the oldest stored word, or the arriving word when nothing is stored.
    always_comb begin
        in_word   = pack_word(data, eod);
        valid     = (num_q != 2'd0) | infl_q;
        head_word = (num_q != 2'd0) ? ent_q[0] : in_word;
        head_dat  = head_word[DATA_MSB:DATA_LSB];
        head_eod  = head_word[EOD_BIT];
        count     = num_q + {1'b0, infl_q};
        cap_eod   = infl_q & eod;
    end

    // Pop shifts the queue; an arriving word is stored unless it was consumed in bypass.
    always_comb begin
        ent_d   = ent_q;
        num_mid = num_q;
        infl_d  = push;
        if (pop && (num_q != 2'd0)) begin
            ent_d[0] = ent_q[1];
            num_mid  = num_q - 2'd1;
        end
        if (infl_q && !(pop && (num_q == 2'd0))) begin
            ent_d[num_mid[0]] = in_word;
            num_mid           = num_mid + 2'd1;
        end
        num_d = num_mid;
    end

    // Buffer state registers.
    always_ff @(posedge clkw or posedge rst) begin
        if (rst) begin
            ent_q  <= '0;
            num_q  <= 2'd0;
            infl_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            num_q  <= num_d;
            infl_q <= infl_d;
        end
    end

endmodule

// File: rtl/pkt_fifo_frame_reader.sv
// Drains committed frames from the packet-body FIFO onto a valid/ready/last byte stream.
// Latency: first byte 3 cycles after commit of an idle reader; then 1 byte/cycle.
// Backpressure: tx_ready low stalls the stream; prefetch stops with 2 words held.
module pkt_fifo_frame_reader
    import pkt_fifo_frame_reader_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int MAX_LEN    = 1518,
    parameter int PEND_W     = 5,
    parameter int LEN_W      = 11
)(
    input  logic                  clkw,
    input  logic                  rst,
    input  logic                  frame_commit,
    input  logic [7:0]            fifo_do,
    input  logic                  fifo_eod,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    pkt_fifo_frame_reader_if.master tx,
    output logic [PEND_W-1:0]     pend_cnt,
    output logic                  pend_ovf,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
);
    localparam int               GAP_W    = $clog2(IFG_CYCLES + 1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
    // GAP spans IFG_CYCLES-1 cycles; the mandatory IDLE cycle completes the gap.
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(IFG_CYCLES - 2);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         frm_q, frm_d;
    logic [7:0]          err_q, err_d;

    logic [7:0]          sk_dat;
    logic                sk_eod, sk_vld, sk_cap_eod;
    logic [1:0]          sk_count;
    logic                tx_vld, at_max, hs, pop;

    // Prefetch runs in every state as long as a committed frame remains.
    assign fifo_re = (pend_q != '0) & ~fifo_empty & (sk_count < 2'd2);

    pkt_reader_skid u_skid (
        .clkw     (clkw),
        .rst      (rst),
        .push     (fifo_re),
        .data     (fifo_do),
        .eod      (fifo_eod),
        .pop      (pop),
        .head_dat (sk_dat),
        .head_eod (sk_eod),
        .valid    (sk_vld),
        .count    (sk_count),
        .cap_eod  (sk_cap_eod)
    );

    // Stream outputs come straight from the buffer head, so they hold while stalled.
    always_comb begin
        tx_vld      = (state_q == ST_STREAM) & sk_vld;
        at_max      = (len_q == LEN_LAST);
        tx.tx_valid = tx_vld;
        tx.tx_data  = tx_vld ? sk_dat : 8'd0;
        tx.tx_last  = tx_vld & (sk_eod | at_max);
        tx.tx_err   = tx_vld & ~sk_eod & at_max;
        hs          = tx_vld & tx.tx_ready;
        pop         = hs | ((state_q == ST_FLUSH) & sk_vld);
    end

    // Frame sequencing: stream, truncate/flush, inter-frame gap.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        frm_d   = frm_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sk_vld) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (hs) begin
                    if (sk_eod || at_max) begin
                        frm_d = frm_q + 16'd1;
                        len_d = '0;
                        gap_d = '0;
                        if (!sk_eod) begin
                            state_d = ST_FLUSH;
                            if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (sk_vld && sk_eod) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_END) state_d = ST_IDLE;
                else                  gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Committed-frame count: commit adds, arrival of an EOD word removes.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (frame_commit && !sk_cap_eod) begin
            if (&pend_q) ovf_d  = 1'b1;
            else         pend_d = pend_q + PEND_W'(1);
        end else if (!frame_commit && sk_cap_eod) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    // All reader state registers.
    always_ff @(posedge clkw or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            frm_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            frm_q   <= frm_d;
            err_q   <= err_d;
        end
    end

    assign pend_cnt  = pend_q;
    assign pend_ovf  = ovf_q;
    assign frame_cnt = frm_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_pkt_fifo_frame_reader.sv
// Bench for pkt_fifo_frame_reader: FIFO model, output scoreboard, per-scenario tasks.
// Latency: n/a.
// Backpressure: tx_ready driven high or randomly toggled.
module tb_pkt_fifo_frame_reader;
    import pkt_fifo_frame_reader_pkg::*;

    localparam int IFG  = 12;
    localparam int MAXL = 1518;

    logic        clkw = 1'b0;
    logic        rst = 1'b1;
    logic        frame_commit = 1'b0;
    logic [7:0]  fifo_do = 8'd0;
    logic        fifo_eod = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_re;
    logic [4:0]  pend_cnt;
    logic        pend_ovf;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    pkt_fifo_frame_reader_if tx_if ();

    pkt_fifo_frame_reader #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL), .PEND_W(5), .LEN_W(11)) dut (
        .clkw         (clkw),
        .rst          (rst),
        .frame_commit (frame_commit),
        .fifo_do      (fifo_do),
        .fifo_eod     (fifo_eod),
        .fifo_empty   (fifo_empty),
        .fifo_re      (fifo_re),
        .tx           (tx_if),
        .pend_cnt     (pend_cnt),
        .pend_ovf     (pend_ovf),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clkw = ~clkw;

    int          tests = 0;
    int          fails = 0;
    word_t       wr_q[$];
    word_t       fifo_q[$];
    word_t       rd_w;
    logic [9:0]  exp_q[$];
    logic [9:0]  got_q[$];
    int          re_viol = 0;
    int          stall_viol = 0;
    int          gap_cnt = 0;
    int          last_gap = -1;
    bit          in_gap = 1'b0;
    bit          stall_pend = 1'b0;
    logic [9:0]  stall_word = '0;
    int          exp_frames = 0;
    int          exp_errs = 0;

    // FIFO model: read data appears one cycle after an accepted read; writes land at the next edge.
    always @(posedge clkw or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            fifo_empty <= 1'b1;
            fifo_do    <= 8'd0;
            fifo_eod   <= 1'b0;
        end else begin
            if (fifo_re) begin
                if (fifo_empty) re_viol++;
                else begin
                    rd_w = fifo_q.pop_front();
                    fifo_do  <= rd_w[DATA_MSB:DATA_LSB];
                    fifo_eod <= rd_w[EOD_BIT];
                end
            end
            while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Output monitor: collects handshaken bytes, stall stability and inter-frame gap length.
    always @(negedge clkw) begin
        if (rst) begin
            stall_pend = 1'b0;
            in_gap     = 1'b0;
        end else begin
            if (stall_pend && (!tx_if.tx_valid ||
                {tx_if.tx_last, tx_if.tx_err, tx_if.tx_data} != stall_word)) stall_viol++;
            stall_pend = tx_if.tx_valid && !tx_if.tx_ready;
            stall_word = {tx_if.tx_last, tx_if.tx_err, tx_if.tx_data};
            if (in_gap) begin
                if (tx_if.tx_valid) begin last_gap = gap_cnt; in_gap = 1'b0; end
                else gap_cnt++;
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                got_q.push_back({tx_if.tx_last, tx_if.tx_err, tx_if.tx_data});
                if (tx_if.tx_last) begin in_gap = 1'b1; gap_cnt = 0; end
            end
        end
    end

    task automatic pulse_commit();
        @(posedge clkw); #1;
        frame_commit = 1'b1;
        @(posedge clkw); #1;
        frame_commit = 1'b0;
    endtask

    // Stages n random bytes (EOD on the last) and records the expected output bytes.
    task automatic write_frame(input int n, input bit commit);
        logic [7:0] b;
        bit trunc;
        bit last;
        trunc = 1'b0;
        @(posedge clkw); #1;
        for (int i = 0; i < n; i++) begin
            b    = 8'($urandom);
            last = (i == n - 1);
            wr_q.push_back(pack_word(b, last));
            if (!trunc) begin
                if (i == MAXL - 1 && !last) begin
                    exp_q.push_back({1'b1, 1'b1, b});
                    trunc = 1'b1;
                end else begin
                    exp_q.push_back({last, 1'b0, b});
                end
            end
        end
        exp_frames++;
        if (trunc) exp_errs++;
        if (commit) pulse_commit();
    endtask

    task automatic wait_got(input int n, input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clkw); #1;
            if (rnd) tx_if.tx_ready = 1'($urandom_range(0, 1));
            if (got_q.size() >= n) begin ok = 1'b1; break; end
        end
        tx_if.tx_ready = 1'b1;
        repeat (20) @(posedge clkw);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, tx_if.tx_err, fifo_re, pend_ovf} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h required=0",
                     {tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, tx_if.tx_err, fifo_re, pend_ovf});
        end
        tests++;
        if ({pend_cnt, frame_cnt, err_cnt} !== 29'd0) begin
            fails++;
            $display("FAIL reset_counters got=%h required=0", {pend_cnt, frame_cnt, err_cnt});
        end
        @(negedge clkw);
        rst = 1'b0;
    endtask

    task automatic test_frame64();
        bit ok;
        int vcnt;
        logic [9:0] e, g;
        write_frame(64, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clkw);
            if (tx_if.tx_valid) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL frame64_start no tx_valid within 20 cycles"); end
        vcnt = 0;
        for (int k = 0; k < 64; k++) begin
            if (tx_if.tx_valid) vcnt++;
            @(negedge clkw);
        end
        tests++;
        if (vcnt != 64) begin fails++; $display("FAIL frame64_contiguous valid_cycles=%0d required=64", vcnt); end
        wait_got(64, 200, 1'b0, ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL frame64_byte got=%h required=%h", g, e); end
        end
        tests++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            fails++; $display("FAIL frame64_count left_exp=%0d left_got=%0d", exp_q.size(), got_q.size());
        end
        tests++;
        if (frame_cnt !== 16'(exp_frames) || pend_cnt !== 5'd0 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL frame64_counters frame=%0d pend=%0d err=%0d required=%0d/0/0",
                              frame_cnt, pend_cnt, err_cnt, exp_frames);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_no_commit();
        bit ok;
        int viol, dly;
        logic [9:0] e, g;
        write_frame(20, 1'b0);
        viol = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clkw);
            if (tx_if.tx_valid || fifo_re) viol++;
        end
        tests++;
        if (viol != 0) begin fails++; $display("FAIL nocommit_idle active_cycles=%0d required=0", viol); end
        pulse_commit();
        dly = 99;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clkw);
            if (tx_if.tx_valid) begin dly = c; break; end
        end
        tests++;
        if (dly > 4) begin fails++; $display("FAIL nocommit_start cycles=%0d required<=4", dly); end
        wait_got(20, 200, 1'b0, ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL nocommit_byte got=%h required=%h", g, e); end
        end
        tests++;
        if (exp_q.size() != 0 || got_q.size() != 0 || frame_cnt !== 16'(exp_frames)) begin
            fails++; $display("FAIL nocommit_count left_exp=%0d left_got=%0d frame=%0d required=%0d",
                              exp_q.size(), got_q.size(), frame_cnt, exp_frames);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [9:0] e, g;
        last_gap = -1;
        write_frame(10, 1'b1);
        write_frame(10, 1'b1);
        wait_got(20, 300, 1'b0, ok);
        tests++;
        if (last_gap != IFG) begin fails++; $display("FAIL b2b_gap idle_cycles=%0d required=%0d", last_gap, IFG); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL b2b_byte got=%h required=%h", g, e); end
        end
        tests++;
        if (exp_q.size() != 0 || got_q.size() != 0 || frame_cnt !== 16'(exp_frames)) begin
            fails++; $display("FAIL b2b_count left_exp=%0d left_got=%0d frame=%0d required=%0d",
                              exp_q.size(), got_q.size(), frame_cnt, exp_frames);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random_ready();
        bit ok;
        logic [9:0] e, g;
        stall_viol = 0;
        write_frame(100, 1'b1);
        wait_got(100, 2000, 1'b1, ok);
        tests++;
        if (stall_viol != 0) begin fails++; $display("FAIL rnd_stall_stable changes=%0d required=0", stall_viol); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL rnd_byte got=%h required=%h", g, e); end
        end
        tests++;
        if (exp_q.size() != 0 || got_q.size() != 0 || frame_cnt !== 16'(exp_frames)) begin
            fails++; $display("FAIL rnd_count left_exp=%0d left_got=%0d frame=%0d required=%0d",
                              exp_q.size(), got_q.size(), frame_cnt, exp_frames);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_max_len();
        bit ok;
        int idx;
        logic [9:0] e, g;
        write_frame(1600, 1'b1);
        write_frame(20, 1'b1);
        wait_got(MAXL + 20, 5000, 1'b0, ok);
        idx = 0;
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++; idx++;
            if (g !== e) begin fails++; $display("FAIL maxlen_byte idx=%0d got=%h required=%h", idx, g, e); end
        end
        tests++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            fails++; $display("FAIL maxlen_count left_exp=%0d left_got=%0d", exp_q.size(), got_q.size());
        end
        tests++;
        if (err_cnt !== 8'(exp_errs) || frame_cnt !== 16'(exp_frames) || pend_cnt !== 5'd0 || fifo_empty !== 1'b1) begin
            fails++; $display("FAIL maxlen_counters err=%0d frame=%0d pend=%0d empty=%b required=%0d/%0d/0/1",
                              err_cnt, frame_cnt, pend_cnt, fifo_empty, exp_errs, exp_frames);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [9:0] e, g;
        write_frame(60, 1'b1);
        wait_got(30, 200, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rstmid_reach got=%0d required>=30", got_q.size()); end
        rst = 1'b1;
        #1;
        tests++;
        if ({tx_if.tx_valid, fifo_re, pend_ovf, pend_cnt, frame_cnt, err_cnt} !== 32'd0) begin
            fails++; $display("FAIL rstmid_clear got=%h required=0",
                              {tx_if.tx_valid, fifo_re, pend_ovf, pend_cnt, frame_cnt, err_cnt});
        end
        exp_q.delete(); got_q.delete(); wr_q.delete();
        exp_frames = 0; exp_errs = 0;
        repeat (2) @(posedge clkw);
        @(negedge clkw);
        rst = 1'b0;
        write_frame(25, 1'b1);
        wait_got(25, 200, 1'b0, ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL rstmid_byte got=%h required=%h", g, e); end
        end
        tests++;
        if (exp_q.size() != 0 || got_q.size() != 0 || frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL rstmid_after left_exp=%0d left_got=%0d frame=%0d err=%0d required=0/0/1/0",
                              exp_q.size(), got_q.size(), frame_cnt, err_cnt);
        end
        tests++;
        if (re_viol != 0) begin fails++; $display("FAIL read_when_empty count=%0d required=0", re_viol); end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        test_reset();
        test_frame64();
        test_no_commit();
        test_back_to_back();
        test_random_ready();
        test_max_len();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached tests=%0d", tests);
        $fatal(1);
    end

endmodule
